md_issue_ctrl: RTL and testbench
================================

Name: md_issue_ctrl

Overview:
- Pipeline-side controller for the multiply/divide unit, located in the E stage. It decodes E-stage instructions and drives the MD unit's command interface (op code, start pulse, operands).
- It tracks MD occupancy with its own latency counter. It stalls the D stage on any HI/LO-family instruction while an operation is in flight.
- It suppresses issue when the E-stage instruction is being flushed by an interrupt or exception.

Parameters:
- MULT_LAT, 5, busy cycles after a mult/multu issue before HI/LO are valid.
- DIV_LAT, 10, busy cycles after a div/divu issue before HI/LO are valid.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_d  in  32  instruction in D stage.
- instr_e  in  32  instruction in E stage.
- rs_e  in  32  forwarded rs operand, E stage.
- rt_e  in  32  forwarded rt operand, E stage.
- flush_e  in  1  E-stage instruction is cancelled this cycle (interrupt/exception).
- md_op  out  3  MD command: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi.
- md_start  out  1  one-cycle start pulse for mult/multu/div/divu.
- md_a  out  32  operand A to MD unit (rs_e).
- md_b  out  32  operand B to MD unit (rt_e).
- hilo_sel  out  2  E-stage read select: 01 mfhi, 10 mflo, 00 none.
- stall_d  out  1  freeze PC/D, insert bubble into E.
- md_busy  out  1  controller state is BUSY.

Behaviour:
- Decode (opcode 000000): mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011. All eight form the "md family".
- md_a = rs_e and md_b = rt_e always (combinational).
- FSM states and transitions:
  - IDLE to BUSY: on issue. Issue = instr_e is mult/multu/div/divu AND !flush_e AND state IDLE.
  - On issue: md_start=1 and md_op=1..4 in the same cycle, combinationally. busy_cnt loads MULT_LAT for mult/multu, DIV_LAT for div/divu.
  - BUSY: busy_cnt decrements each cycle. When busy_cnt==1, the next state is IDLE and busy_cnt becomes 0.
  - md_busy = (state==BUSY).
- mtlo/mthi in E with !flush_e: md_op=5/6, md_start=0, no state change.
- flush_e high forces md_op=0, md_start=0 and hilo_sel=00 that cycle.
- flush_e while BUSY does not cancel the in-flight operation; the counter keeps running.
- stall_d = md_family(instr_d) AND (issue OR state==BUSY).
  - The D-stage instruction enters E the cycle after BUSY ends, i.e. L+1 cycles after the issue cycle.
  - Non-md instructions never stall.
- An md arithmetic instruction in E while BUSY is impossible by construction: it is held in D by stall_d. If it occurs anyway (e.g. bench forcing), it is ignored (no start) and the count is not reloaded.
- Divide by zero is issued normally with full DIV_LAT.
- busy_cnt width: ceil(log2(max(MULT_LAT,DIV_LAT)+1)).
- Reset values, applied at any time including mid-operation: state IDLE, busy_cnt 0, md_busy 0. Combinational outputs then evaluate with state IDLE.
- The in-flight MD result is discarded by the MD unit's own reset; no replay.

Test Plan:
- mult in E (rs=7, rt=6) -> md_start=1, md_op=1, md_a=7, md_b=6 that cycle. md_busy high exactly 5 cycles, then low.
- div issued, then mflo in D the next cycle -> stall_d high for 10 cycles. mflo enters E on cycle 11 with hilo_sel=10.
- mult with flush_e=1 in the same cycle -> md_start=0, md_op=0, md_busy stays 0. A following mfhi in D is not stalled.
- divu issued, then flush_e=1 at BUSY cycle 4 -> md_busy still drops after exactly 10 cycles total.
- addu in D during BUSY -> stall_d=0. mthi in D during BUSY -> stall_d=1 until IDLE, then md_op=6 with md_start=0.
- Assert reset at BUSY cycle 3 of a div -> md_busy=0 immediately (async). A mflo in D is released the same cycle.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage issue controller for the multiply/divide unit.
// It decodes the E-stage instruction, drives the MD command interface,
// tracks MD occupancy with a latency down-counter and stalls D on any
// HI/LO-family instruction while an operation is in flight.
//
// state  | meaning
// -------+-------------------------------------------------------
// IDLE   | MD unit free, an arithmetic op in E may issue
// BUSY   | mult/div in flight, busy_cnt counts cycles remaining
module md_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic [31:0] instr_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  input  logic        flush_e,
  output logic [2:0]  md_op,
  output logic        md_start,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic [1:0]  hilo_sel,
  output logic        stall_d,
  output logic        md_busy
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] busy_cnt_q, busy_cnt_d;

  logic       rtype_d, rtype_e;
  logic [5:0] funct_d, funct_e;
  logic       fam_d, arith_e, is_mult_e;
  logic       issue;

  // Only opcode and funct fields matter for this decoder.
  logic unused_fields;
  assign unused_fields = ^{instr_d[25:6], instr_e[25:6]};

  assign rtype_d = (instr_d[31:26] == 6'b000000);
  assign rtype_e = (instr_e[31:26] == 6'b000000);
  assign funct_d = instr_d[5:0];
  assign funct_e = instr_e[5:0];

  assign md_a    = rs_e;
  assign md_b    = rt_e;
  assign md_busy = (state_q == S_BUSY);

  // Decode and command generation for the current E/D instructions.
  always_comb begin
    fam_d     = 1'b0;
    arith_e   = 1'b0;
    is_mult_e = 1'b0;
    md_op     = 3'd0;
    hilo_sel  = 2'b00;

    if (rtype_d) begin
      case (funct_d)
        F_MFHI, F_MTHI, F_MFLO, F_MTLO,
        F_MULT, F_MULTU, F_DIV, F_DIVU: fam_d = 1'b1;
        default:                        fam_d = 1'b0;
      endcase
    end

    if (rtype_e) begin
      arith_e   = (funct_e[5:2] == 4'b0110);
      is_mult_e = (funct_e == F_MULT) || (funct_e == F_MULTU);
    end

    // Arithmetic ops arriving in E while BUSY are dropped without a start.
    issue    = arith_e && !flush_e && (state_q == S_IDLE);
    md_start = issue;

    if (!flush_e && rtype_e) begin
      if (issue) begin
        md_op = {1'b0, funct_e[1:0]} + 3'd1;
      end else if (funct_e == F_MTLO) begin
        md_op = 3'd5;
      end else if (funct_e == F_MTHI) begin
        md_op = 3'd6;
      end

      if (funct_e == F_MFHI) begin
        hilo_sel = 2'b01;
      end else if (funct_e == F_MFLO) begin
        hilo_sel = 2'b10;
      end
    end

    stall_d = fam_d && (issue || (state_q == S_BUSY));
  end

  // Next-state and latency counter; flush does not cancel an op in flight.
  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d    = S_BUSY;
          busy_cnt_d = is_mult_e ? CW'(MULT_LAT) : CW'(DIV_LAT);
        end
      end
      S_BUSY: begin
        if (busy_cnt_q <= CW'(1)) begin
          state_d    = S_IDLE;
          busy_cnt_d = '0;
        end else begin
          busy_cnt_d = busy_cnt_q - CW'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        busy_cnt_d = '0;
      end
    endcase
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenarios plus random
// instruction streams checked against a time-window occupancy model.
module tb_md_issue_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_d = '0, instr_e = '0, rs_e = '0, rt_e = '0;
  logic        flush_e = 1'b0;
  logic [2:0]  md_op;
  logic        md_start;
  logic [31:0] md_a, md_b;
  logic [1:0]  hilo_sel;
  logic        stall_d, md_busy;

  int total = 0;
  int bad   = 0;

  // Model: the op issued at cycle t_iss occupies cycles [t_iss, t_iss+lat).
  int cyc   = 0;
  int t_iss = -1;
  int lat   = 0;

  md_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .instr_e(instr_e),
    .rs_e(rs_e), .rt_e(rt_e), .flush_e(flush_e), .md_op(md_op),
    .md_start(md_start), .md_a(md_a), .md_b(md_b), .hilo_sel(hilo_sel),
    .stall_d(stall_d), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] f);
    mk = {6'b000000, 5'd3, 5'd4, 5'd0, 5'd0, f};
  endfunction

  function automatic bit is_r(input logic [31:0] i);
    is_r = (i[31:26] == 6'd0);
  endfunction

  function automatic bit in_family(input logic [31:0] i);
    in_family = is_r(i) && (i[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13,
                                           6'h18, 6'h19, 6'h1a, 6'h1b});
  endfunction

  function automatic bit model_busy();
    model_busy = (t_iss >= 0) && (cyc >= t_iss) && (cyc < t_iss + lat);
  endfunction

  // Compare all outputs against the rule-level expectation; return issue.
  task automatic check_outs(output bit iss);
    bit      busy, arith;
    int      op, hs;
    int      f;
    busy  = model_busy();
    f     = int'(instr_e[5:0]);
    arith = is_r(instr_e) && (f >= 24) && (f <= 27);
    iss   = arith && !flush_e && !busy;
    op = 0;
    hs = 0;
    if (!flush_e && is_r(instr_e)) begin
      if (iss)          op = f - 24 + 1;
      else if (f == 19) op = 5;
      else if (f == 17) op = 6;
      if (f == 16)      hs = 1;
      else if (f == 18) hs = 2;
    end
    chk("md_busy",  {31'd0, md_busy},  {31'd0, busy});
    chk("md_start", {31'd0, md_start}, {31'd0, iss});
    chk("md_op",    {29'd0, md_op},    op);
    chk("hilo_sel", {30'd0, hilo_sel}, hs);
    chk("md_a",     md_a, rs_e);
    chk("md_b",     md_b, rt_e);
    chk("stall_d",  {31'd0, stall_d},  {31'd0, in_family(instr_d) && (iss || busy)});
  endtask

  task automatic step();
    bit iss;
    int f;
    #2;
    check_outs(iss);
    f = int'(instr_e[5:0]);
    @(posedge clk);
    cyc++;
    if (iss && !reset) begin
      t_iss = cyc;
      lat   = (f <= 25) ? MULT_LAT : DIV_LAT;
    end
    #1;
  endtask

  task automatic reset_pulse();
    bit iss;
    reset = 1'b1;
    t_iss = -1;
    #1;
    check_outs(iss);
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fl [10];
    fl = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h21, 6'h00};
    case ($urandom_range(0, 9))
      0:       rand_instr = $urandom;
      1, 2:    rand_instr = 32'd0;
      default: rand_instr = mk(fl[$urandom_range(0, 9)]);
    endcase
  endfunction

  initial begin
    int n;
    bit seen;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_busy", {31'd0, md_busy}, 32'd0);

    // mult issue with operands, then busy for exactly MULT_LAT cycles
    instr_e = mk(6'h18); rs_e = 32'd7; rt_e = 32'd6; instr_d = '0;
    #1;
    chk("mult_start", {31'd0, md_start}, 32'd1);
    chk("mult_op", {29'd0, md_op}, 32'd1);
    chk("mult_a", md_a, 32'd7);
    chk("mult_b", md_b, 32'd6);
    step();
    instr_e = '0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (md_busy) n++;
      step();
    end
    chk("mult_busy_len", n, MULT_LAT);

    // div then mflo in D: held for DIV_LAT cycles, then reads LO in E
    instr_e = mk(6'h1a); instr_d = '0;
    step();
    instr_e = '0; instr_d = mk(6'h12);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!stall_d) break;
      n++;
      step();
    end
    chk("div_stall_len", n, DIV_LAT);
    instr_e = mk(6'h12); instr_d = '0;
    #1;
    chk("mflo_sel", {30'd0, hilo_sel}, 32'd2);
    step();

    // flushed mult never issues; mfhi in D not stalled
    instr_e = mk(6'h18); flush_e = 1'b1; instr_d = mk(6'h10);
    #1;
    chk("flush_start", {31'd0, md_start}, 32'd0);
    chk("flush_op", {29'd0, md_op}, 32'd0);
    chk("flush_stall", {31'd0, stall_d}, 32'd0);
    step();
    flush_e = 1'b0; instr_e = '0;
    #1;
    chk("flush_busy", {31'd0, md_busy}, 32'd0);
    step();

    // divu with a flush at busy cycle 4 still runs DIV_LAT cycles
    instr_e = mk(6'h1b); instr_d = '0;
    step();
    instr_e = '0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      flush_e = (i == 3);
      if (md_busy) n++;
      step();
    end
    flush_e = 1'b0;
    chk("divu_flush_len", n, DIV_LAT);

    // addu in D not stalled; mthi held until idle then md_op=6
    instr_e = mk(6'h19);
    step();
    instr_e = '0; instr_d = mk(6'h21);
    #1;
    chk("addu_nostall", {31'd0, stall_d}, 32'd0);
    step();
    instr_d = mk(6'h11);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (!stall_d) break;
      n++;
      step();
    end
    chk("mthi_stall_len", n, MULT_LAT - 1);
    instr_e = mk(6'h11); instr_d = '0;
    #1;
    chk("mthi_op", {29'd0, md_op}, 32'd6);
    chk("mthi_start", {31'd0, md_start}, 32'd0);
    step();

    // async reset at busy cycle 3 of a div releases a stalled mflo
    instr_e = mk(6'h1a); instr_d = '0;
    step();
    instr_e = '0; instr_d = mk(6'h12);
    step(); step();
    #1;
    chk("pre_reset_stall", {31'd0, stall_d}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_busy", {31'd0, md_busy}, 32'd0);
    chk("async_stall", {31'd0, stall_d}, 32'd0);
    t_iss = -1;
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    step();

    // randomized stream with occasional flushes and async resets
    seen = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      instr_d = rand_instr();
      instr_e = rand_instr();
      rs_e    = $urandom;
      rt_e    = $urandom;
      flush_e = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) == 0) begin
        reset_pulse();
      end else begin
        if (model_busy()) seen = 1'b1;
        step();
      end
    end
    chk("random_saw_busy", {31'd0, seen}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
